// File: rtl/instruction_memory.sv
// Small program store for the fetch stage: combinational read, synchronous patch port,
// and an asynchronous reset that reloads the built-in default program.
`timescale 1ns/1ps

module instruction_memory #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] instruct,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Built-in boot program; the unused middle is NOPs and the top word halts the core.
    function automatic logic [DATA_WIDTH-1:0] default_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        if (a == {ADDR_WIDTH{1'b1}}) begin
            w = {DATA_WIDTH{1'b1}};
        end else begin
            case (a)
                ADDR_WIDTH'(0): w = DATA_WIDTH'(8'h11);
                ADDR_WIDTH'(1): w = DATA_WIDTH'(8'h26);
                ADDR_WIDTH'(2): w = DATA_WIDTH'(8'h39);
                ADDR_WIDTH'(3): w = DATA_WIDTH'(8'h4E);
                ADDR_WIDTH'(4): w = DATA_WIDTH'(8'h52);
                ADDR_WIDTH'(5): w = DATA_WIDTH'(8'h67);
                ADDR_WIDTH'(6): w = DATA_WIDTH'(8'h7B);
                default:        w = '0;
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word(ADDR_WIDTH'(i));
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // While reset is held the default image is presented directly, so the read is
    // correct from the instant reset rises and no stale write can leak through.
    always_comb begin
        instruct = mem[address];
        if (reset) begin
            instruct = default_word(address);
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: expected words are queued as stimulus is
// driven and compared once the combinational read has settled.
`timescale 1ns/1ps

module tb_instruction_memory;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          we       = 1'b0;
    logic [AW-1:0] address  = '0;
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic [DW-1:0] instruct;
    bit            clkRun   = 1'b0;

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic [DW-1:0] defaults [DEPTH] = '{8'h11, 8'h26, 8'h39, 8'h4E, 8'h52, 8'h67, 8'h7B,
                                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                        8'h00, 8'hFF};

    instruction_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .instruct (instruct),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    // Clock can be held still so the read path is exercised with no edges at all.
    initial begin
        forever begin
            #5;
            if (clkRun) clk = ~clk;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: instruct=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, instruct, e.exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        address = a;
        expQ.push_back('{tag, exp});
        #1;
        drainScoreboard();
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        $display("[TB] start");

        // Reset pulse with the clock stopped; read is valid while reset is still high.
        #1 reset = 1'b1;
        applyStimulus("rst_hold_a0", 4'd0, 8'h11);
        applyStimulus("rst_hold_a15", 4'd15, 8'hFF);
        #3 reset = 1'b0;
        #5;

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("dflt_a%0d", i), AW'(i), defaults[i]);
            #9;
        end
        applyStimulus("dflt_a15", 4'd15, 8'hFF);
        #9;
        for (int i = 7; i < 15; i++) begin
            applyStimulus($sformatf("nop_a%0d", i), AW'(i), 8'h00);
            #9;
        end

        clkRun = 1'b1;
        #20;

        // Read-during-write at the same address: old word before the edge, new after.
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'hA5;
        applyStimulus("rdw_before", 4'd3, 8'h4E);
        @(posedge clk);
        #1;
        we = 1'b0;
        applyStimulus("rdw_after", 4'd3, 8'hA5);
        applyStimulus("neighbor_a2", 4'd2, 8'h39);

        writeWord(4'd9, 8'h12);
        writeWord(4'd9, 8'h34);
        applyStimulus("last_wins_a9", 4'd9, 8'h34);

        // Async reset between edges discards every prior write immediately.
        writeWord(4'd15, 8'h5A);
        applyStimulus("wr_a15", 4'd15, 8'h5A);
        @(negedge clk);
        #2 reset = 1'b1;
        applyStimulus("async_rst_a15", 4'd15, 8'hFF);
        applyStimulus("rst_discard_a3", 4'd3, 8'h4E);
        applyStimulus("rst_discard_a9", 4'd9, 8'h00);

        // Write attempt while reset is held must be ignored.
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 4'd0;
        wr_data = 8'hC3;
        @(posedge clk);
        #1;
        applyStimulus("rst_blocks_we", 4'd0, 8'h11);
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b0;
        #1;
        applyStimulus("after_release_a0", 4'd0, 8'h11);
        applyStimulus("after_release_a15", 4'd15, 8'hFF);

        for (int i = 0; i < DEPTH; i++) begin
            writeWord(AW'(i), ~DW'(i));
        end
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus($sformatf("sweep_a%0d", i), AW'(i), ~DW'(i));
        end

        clkRun = 1'b0;
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
